// File: rtl/mips_fetch_queue.sv
// MIPS32 instruction-fetch front end: issues word reads, buffers {instr, pc} pairs in a
// small FIFO, hands them to decode over valid/ready, and handles redirects and HLT.

module mips_fetch_queue_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          clk,
    input logic          rst_n,
    input logic          push_i,
    input logic          pop_i,
    input logic [CW-1:0] count_i
);
    // The issue rule must never let a response land in a full FIFO
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !pop_i && (count_i == CW'(DEPTH))));

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count_i <= CW'(DEPTH));
endmodule

module mips_fetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    imem_req,
    output logic [ADDR_W-1:0]       imem_addr,
    input  logic                    imem_rvalid,
    input  logic [31:0]             imem_rdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_instr,
    output logic [ADDR_W-1:0]       out_pc,
    input  logic                    redirect,
    input  logic [ADDR_W-1:0]       redirect_pc,
    output logic                    halted,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    function automatic logic is_hlt(input logic [31:0] word);
        return word[31:26] == 6'h3f;
    endfunction

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              inflight_q, inflight_d;
    logic              drop_q, drop_d;
    logic              halt_seen_q, halt_seen_d;
    logic              halted_q, halted_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [31:0]       ent_instr_q [DEPTH];
    logic [ADDR_W-1:0] ent_pc_q    [DEPTH];

    logic issue_s;
    logic push_s;
    logic pop_s;
    logic valid_s;

    // Handshake decisions; requests are suppressed while reset is asserted
    always_comb begin
        valid_s = (count_q != {CW{1'b0}}) && !redirect;
        issue_s = rst_n && !redirect && !halt_seen_q &&
                  ((count_q + CW'(inflight_q)) < CW'(DEPTH));
        push_s  = imem_rvalid && inflight_q && !drop_q && !halt_seen_q && !redirect;
        pop_s   = valid_s && out_ready;
    end

    // Next-state logic; a redirect overrides every other update
    always_comb begin
        pc_d        = pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        halt_seen_d = halt_seen_q;
        halted_d    = halted_q;
        drop_d      = drop_q;
        inflight_d  = issue_s;
        req_pc_d    = issue_s ? pc_q : req_pc_q;
        if (redirect) begin
            pc_d        = redirect_pc;
            wr_ptr_d    = {PW{1'b0}};
            rd_ptr_d    = {PW{1'b0}};
            count_d     = {CW{1'b0}};
            halt_seen_d = 1'b0;
            halted_d    = 1'b0;
            // An outstanding read whose data has not shown up yet must be discarded later
            drop_d      = inflight_q && !imem_rvalid;
        end else begin
            pc_d     = issue_s ? (pc_q + {{(ADDR_W-1){1'b0}}, 1'b1}) : pc_q;
            wr_ptr_d = wr_ptr_q + PW'(push_s);
            rd_ptr_d = rd_ptr_q + PW'(pop_s);
            count_d  = count_q + CW'(push_s) - CW'(pop_s);
            drop_d   = imem_rvalid ? 1'b0 : drop_q;
            if (push_s && is_hlt(imem_rdata)) begin
                halt_seen_d = 1'b1;
            end else begin
                halt_seen_d = halt_seen_q;
            end
            if (pop_s && is_hlt(ent_instr_q[rd_ptr_q])) begin
                halted_d = 1'b1;
            end else begin
                halted_d = halted_q;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= {ADDR_W{1'b0}};
            inflight_q  <= 1'b0;
            drop_q      <= 1'b0;
            halt_seen_q <= 1'b0;
            halted_q    <= 1'b0;
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
        end else begin
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            inflight_q  <= inflight_d;
            drop_q      <= drop_d;
            halt_seen_q <= halt_seen_d;
            halted_q    <= halted_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage, written only by an accepted response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_instr_q[i] <= 32'h0;
                ent_pc_q[i]    <= {ADDR_W{1'b0}};
            end
        end else if (push_s) begin
            ent_instr_q[wr_ptr_q] <= imem_rdata;
            ent_pc_q[wr_ptr_q]    <= req_pc_q;
        end
    end

    assign imem_req  = issue_s;
    assign imem_addr = pc_q;
    assign out_valid = valid_s;
    assign out_instr = ent_instr_q[rd_ptr_q];
    assign out_pc    = ent_pc_q[rd_ptr_q];
    assign halted    = halted_q;
    assign count     = count_q;

    mips_fetch_queue_chk #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .count_i (count_q)
    );
endmodule

// File: doc/mips_fetch_queue.md
Name: mips_fetch_queue

Overview:
- Instruction-fetch front end of the pipelined MIPS32 core.
- Issues word-addressed reads to instruction memory and buffers returned instructions, each tagged with its PC, in a small FIFO.
- Hands instructions to the decode stage over a valid/ready handshake.
- Handles branch redirects (flush) and stops fetching after HLT (opcode 6'h3f).

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2).
- ADDR_W, 32, PC / memory word-address width.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  read request this cycle.
- imem_addr  output  ADDR_W  word address of the request.
- imem_rvalid  input  1  read data valid; asserted exactly one cycle after imem_req.
- imem_rdata  input  32  instruction word.
- out_valid  output  1  head entry available to decode.
- out_ready  input  1  decode accepts head entry.
- out_instr  output  32  head instruction.
- out_pc  output  ADDR_W  head instruction address.
- redirect  input  1  branch taken; flush and refetch.
- redirect_pc  input  ADDR_W  new fetch address.
- halted  output  1  HLT delivered; fetch stopped.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, rst_n=0):
  - fetch PC=RESET_PC; FIFO empty; in-flight flag, drop flag, halt_seen and halted cleared.
  - Outputs: imem_req=0, out_valid=0, count=0, halted=0; out_instr/out_pc=0.
  - Reset mid-operation discards everything, including a response arriving in the first cycle after release.
- PC increments by 1 per issued request (word addressing). Wraps modulo 2^ADDR_W.
- In-flight flag = request issued last cycle.
- Issue rule:
  - imem_req=1 iff !redirect && !halt_seen && (count + inflight) < DEPTH.
  - imem_addr = fetch PC. Fetch PC advances on issue.
  - Memory is always ready; at most one request is in flight.
- Enqueue:
  - imem_rvalid && !drop → push {imem_rdata, pc of that request}.
  - Space is guaranteed by the issue rule; overflow is impossible. An assertion flags it.
- Dequeue:
  - out_valid = (count!=0) && !redirect.
  - Pop when out_valid && out_ready. Push and pop in the same cycle leave count unchanged.
  - Empty FIFO plus arriving data: data appears at the head the next cycle (no bypass).
  - Best-case latency: req in cycle N, rdata in N+1, out_valid in N+2.
- Redirect (priority over all other actions):
  - In the redirect cycle: FIFO cleared, no pop counted, no request issued.
  - A response arriving that cycle is dropped. drop is set if a request is in flight, so the next response is also discarded.
  - Fetch PC=redirect_pc; halt_seen and halted are cleared.
  - First request to redirect_pc is issued in the following cycle.
- HLT:
  - When an enqueued word has imem_rdata[31:26]==6'h3f, set halt_seen; no further requests are issued.
  - A response already in flight behind the HLT is dropped.
  - Entries before and including HLT are still delivered in order.
  - halted=1 the cycle after the HLT entry is popped. It stays set until redirect or reset.
- Simultaneous redirect and HLT enqueue: redirect wins; HLT is discarded and halt_seen stays 0.
- count never exceeds DEPTH. out_instr/out_pc are held stable while out_valid && !out_ready.

Test Plan:
- Reset/idle: hold rst_n=0 with imem_rvalid pulsing → imem_req=0, out_valid=0, count=0, halted=0. Release → imem_req=1, imem_addr=0 the first cycle after.
- Streaming: memory returns Mem[k]=32'h28000000+k, out_ready=1 → one instruction per cycle after 2-cycle fill. Sequence is out_pc 0,1,2,3… with matching out_instr and no gaps.
- Backpressure: out_ready=0 → count saturates at 4 and imem_req drops, with exactly 4 requests issued (addresses 0–3). Raise out_ready → PCs 0..3 drain in order and fetching resumes at address 4 with no lost or duplicated PCs.
- Redirect with in-flight read: at steady state assert redirect, redirect_pc=5, for one cycle → FIFO flushed, in-flight response dropped, next imem_addr=5. First delivered out_pc=5, instruction 32'h14431000.
- Halt: Mem[10]=32'hfc000000, fetch from 8 → out_pc 8,9,10 delivered, no request for address >11 is accepted, the response for 11 is dropped, and halted=1 one cycle after PC 10 pops. A later redirect to 0 clears halted and restarts fetching.
- Async reset mid-stream: drop rst_n between clock edges while count=3 → count=0 and out_valid=0 immediately, without waiting for a clock edge. Fetch restarts at RESET_PC.
